// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised 2R/1W byte-strobed register file with hardware clear sequencer
// Same-cycle write-to-read forwarding is built only when REGFILE_BYPASS_EN is defined.

module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [ADDR_W-1:0]   raddr1,
  input  logic [ADDR_W-1:0]   raddr2,
  output logic [DATA_W-1:0]   rdata1,
  output logic [DATA_W-1:0]   rdata2,
  input  logic                clr_req,
  output logic                busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_ptr, clr_ptr_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_en;
  logic [DATA_W-1:0]   wr_merge;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      CLEAR: begin
        clr_ptr_nxt = clr_ptr + ADDR_W'(1);
        if (clr_ptr == LAST_PTR) begin
          state_nxt   = IDLE;
          clr_ptr_nxt = '0;
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_ptr_nxt = '0;
        end
      end
    endcase
  end

  assign busy  = (state == CLEAR);
  assign wr_en = we && !busy && !(ZERO_REG && (waddr == '0));

  // Strobed bytes from wdata, the rest from the stored word; shared by write and bypass.
  always_comb begin
    wr_merge = mem[waddr];
    for (int i = 0; i < NB; i++) begin
      if (wstrb[i]) wr_merge[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_ptr] <= '0;
    end else if (wr_en) begin
      mem[waddr] <= wr_merge;
    end
  end

  always_comb begin
    rdata1 = mem[raddr1];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (raddr1 == waddr)) rdata1 = wr_merge;
`endif
    if (busy || (ZERO_REG && (raddr1 == '0))) rdata1 = '0;
  end

  always_comb begin
    rdata2 = mem[raddr2];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (raddr2 == waddr)) rdata2 = wr_merge;
`endif
    if (busy || (ZERO_REG && (raddr2 == '0))) rdata2 = '0;
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - randomized and directed bench for regfile_param against a word-array model
// Expectations for same-cycle reads follow REGFILE_BYPASS_EN.

module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic        clr_req = 1'b0;
  logic [31:0] rd1_z, rd2_z, rd1_n, rd2_n;
  logic        busy_z, busy_n;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_z [32];
  logic [31:0] m_n [32];
  int          clr_left = 0;

  always #5 clk = ~clk;

  regfile_param dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_z), .rdata2(rd2_z),
    .clr_req(clr_req), .busy(busy_z)
  );

  regfile_param #(.ZERO_REG(1'b0)) dut_nz (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_n), .rdata2(rd2_n),
    .clr_req(clr_req), .busy(busy_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old);
    logic [31:0] v;
    v = old;
    for (int i = 0; i < 4; i++) if (wstrb[i]) v[8*i +: 8] = wdata[8*i +: 8];
    return v;
  endfunction

  function automatic logic [31:0] exp_rd(input bit zr, input logic [4:0] a);
    logic [31:0] v;
    if (clr_left > 0) return 32'h0;
    if (zr && a == 5'd0) return 32'h0;
    v = zr ? m_z[a] : m_n[a];
`ifdef REGFILE_BYPASS_EN
    if (we && a == waddr && !(zr && waddr == 5'd0)) v = merge(v);
`endif
    return v;
  endfunction

  // Clearing the whole model array at clear start is equivalent: reads are forced to zero
  // and writes are dropped until the sweep finishes.
  task automatic model_update();
    if (clr_left == 0 && we) begin
      if (waddr != 5'd0) m_z[waddr] = merge(m_z[waddr]);
      m_n[waddr] = merge(m_n[waddr]);
    end
    if (rst || (clr_left == 0 && clr_req)) begin
      clr_left = 32;
      for (int i = 0; i < 32; i++) begin
        m_z[i] = '0;
        m_n[i] = '0;
      end
    end else if (clr_left > 0) begin
      clr_left--;
    end
  endtask

  task automatic step();
    #2;
    if (chk_en) begin
      check("rd1_z", rd1_z, exp_rd(1'b1, raddr1));
      check("rd2_z", rd2_z, exp_rd(1'b1, raddr2));
      check("rd1_n", rd1_n, exp_rd(1'b0, raddr1));
      check("rd2_n", rd2_n, exp_rd(1'b0, raddr2));
      check("busy_z", 32'(busy_z), 32'(clr_left > 0));
      check("busy_n", 32'(busy_n), 32'(clr_left > 0));
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    we = 1'b1; waddr = a; wdata = d; wstrb = s;
    step();
    we = 1'b0;
  endtask

  // Counts sampled busy cycles, issuing random (droppable) writes and an optional clr_req at cycle req_at.
  task automatic busy_window(output int n, input int req_at);
    n = 0;
    while (busy_z && n < 100) begin
      n++;
      we = 1'b1; waddr = 5'($urandom); wdata = $urandom; wstrb = 4'($urandom);
      clr_req = (n == req_at);
      step();
    end
    we = 1'b0;
    clr_req = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] exp;

    step();
    rst = 1'b0;
    chk_en = 1'b1;
    busy_window(n, -1);
    check("init_busy_len", n, 32);

    for (int i = 1; i < 32; i++) wr(5'(i), 32'hFFFF_FFFF, 4'hF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    busy_window(n, -1);
    check("rst_busy_len", n, 32);
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      #1;
      check("clr_zero_z", rd1_z, 32'h0);
      check("clr_zero_n", rd2_n, 32'h0);
      step();
    end

    wr(5'd5, 32'h1122_3344, 4'b1111);
    wr(5'd5, 32'hAABB_CCDD, 4'b0101);
    raddr1 = 5'd5;
    #1;
    check("strobe", rd1_z, 32'h11BB_33DD);
    step();
    wr(5'd5, 32'h5555_5555, 4'b0000);
    #1;
    check("strobe_none", rd1_z, 32'h11BB_33DD);
    step();

    we = 1'b1; waddr = 5'd0; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; raddr1 = 5'd0;
    #1;
    check("zr_same", rd1_z, 32'h0);
    step();
    we = 1'b0;
    #1;
    check("zr_next", rd1_z, 32'h0);
    check("nz_next", rd1_n, 32'hDEAD_BEEF);
    step();

    wr(5'd7, 32'h1234_5678, 4'hF);
    we = 1'b1; waddr = 5'd7; wdata = 32'hCAFE_F00D; wstrb = 4'hF; raddr1 = 5'd7; raddr2 = 5'd7;
`ifdef REGFILE_BYPASS_EN
    exp = 32'hCAFE_F00D;
`else
    exp = 32'h1234_5678;
`endif
    #1;
    check("bypass_p1", rd1_z, exp);
    check("bypass_p2", rd2_z, exp);
    step();
    we = 1'b0;
    #1;
    check("after_p1", rd1_z, 32'hCAFE_F00D);
    check("after_p2", rd2_z, 32'hCAFE_F00D);
    step();

    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    busy_window(n, -1);
    check("midclr_busy_len", n, 32);

    wr(5'd3, 32'h0BAD_F00D, 4'hF);
    clr_req = 1'b1;
    step();
    busy_window(n, 5);
    check("req_in_busy_len", n, 32);
    clr_req = 1'b1;
    step();
    busy_window(n, -1);
    check("req_at_fall_len", n, 32);
    raddr1 = 5'd3;
    #1;
    check("reclr_zero", rd1_n, 32'h0);
    step();

    for (int i = 0; i < 1500; i++) begin
      we      = 1'($urandom_range(0, 1));
      waddr   = 5'($urandom);
      wdata   = $urandom;
      wstrb   = 4'($urandom);
      raddr1  = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
      raddr2  = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
      clr_req = ($urandom_range(0, 199) == 0);
      rst     = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    clr_req = 1'b0;
    we = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised general-purpose register file for the CPU datapath: two asynchronous read ports and one byte-strobed synchronous write port. Entry 0 is optionally hardwired to zero. A hardware clear sequencer zeroes the array one entry per cycle after reset or on request. Optional same-cycle write-to-read bypass is available. It replaces the fixed 32×32 register file in the decode/writeback path.

## Interface
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, when 1, entry 0 reads as 0 and ignores writes.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte write strobes; bit i covers wdata[8i+7:8i].
- raddr1, raddr2  in  ADDR_W  read addresses.
- rdata1, rdata2  out  DATA_W  read data, combinational.
- clr_req  in  1  one-cycle pulse requesting a full array clear.
- busy  out  1  high while the clear sequencer runs.

## Operation
- FSM has two states: CLEAR and IDLE.
  - CLEAR: the internal counter clr_ptr (ADDR_W bits) selects one entry, which is written with 0 on each cycle. clr_ptr then increments.
  - When clr_ptr == DEPTH-1 is written, the FSM goes to IDLE next cycle.
- rst sampled high forces state = CLEAR and clr_ptr = 0, from any state.
- In IDLE, clr_req sampled high moves the FSM to CLEAR with clr_ptr = 0. clr_req in CLEAR is ignored.
- Write (IDLE only) when we=1 and not (ZERO_REG && waddr==0):
  - for each i with wstrb[i]=1, entry[waddr] byte i <= wdata byte i;
  - bytes with wstrb[i]=0 are unchanged.
- we=1 with wstrb=0 is legal and has no effect.
- Writes presented while busy=1 are dropped silently; the upstream stalls on busy.
- Read: rdata = entry[raddr].
  - Forced to 0 when busy=1.
  - Forced to 0 when ZERO_REG=1 and raddr==0.
- The two read ports are independent and may address the same entry.

## Timing
- Reset values: busy=1 from the cycle after rst is sampled high. rdata1/rdata2=0 throughout the clear.
- A clear takes exactly DEPTH cycles; busy falls on the posedge after entry DEPTH-1 is cleared.
- Reset asserted mid-clear restarts the sweep at 0 and extends busy by a full DEPTH cycles from the last rst cycle.
- rst and clr_req high in the same cycle: rst governs; the result is identical to rst alone.
- clr_req arriving on the cycle busy falls (FSM already IDLE) starts a new clear.
- Write latency: data is visible on rdata from the cycle after the write edge. Same-cycle behaviour is defined under Configuration.
- Read latency: zero cycles (combinational from raddr and array state).

## Configuration
- REGFILE_BYPASS_EN defined:
  - When we=1, busy=0, raddrN==waddr and the write is not suppressed by ZERO_REG, rdataN equals the merge in the same cycle: strobed bytes from wdata, other bytes from the stored entry.
  - Supplies writeback-to-decode forwarding.
- REGFILE_BYPASS_EN undefined: rdataN shows the pre-write stored value in that cycle and the new value from the next cycle. There is no bypass mux.

## Test plan
- Reset clear:
  - Preload entries 1..31 with 0xFFFFFFFF, pulse rst for 1 cycle.
  - Required: busy=1 for exactly 32 cycles, writes during busy dropped, then every entry reads 0x00000000.
- Byte strobes:
  - Write 0x11223344 to r5 with wstrb=4'b1111, then 0xAABBCCDD with wstrb=4'b0101.
  - Required: r5 reads 0x11BB33DD.
- Zero register:
  - ZERO_REG=1: write 0xDEADBEEF to r0.
  - Required: rdata1 with raddr1=0 is 0 on the same cycle and the next cycle.
  - ZERO_REG=0: r0 reads 0xDEADBEEF on the next cycle.
- Bypass:
  - Write 0xCAFEF00D to r7 while raddr1=raddr2=7; r7 previously held 0x12345678.
  - With REGFILE_BYPASS_EN: both ports show 0xCAFEF00D the same cycle.
  - Without: both ports show 0x12345678 that cycle and 0xCAFEF00D the next cycle.
- Reset mid-clear:
  - Pulse clr_req; on sweep cycle 10, pulse rst.
  - Required: busy stays high 32 further cycles from the rst cycle; all entries read 0 afterward.
- Request edge cases:
  - clr_req during busy: required to have no effect on busy duration.
  - clr_req the cycle busy falls: required to produce a fresh 32-cycle busy window.
